// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the queue entry type for the instruction fetch queue
package fetch_pkg;
  localparam int INSTR_W = 16;
  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] PC_INCR = 16'h0002;
  localparam logic [PC_W-1:0] RESET_VECTOR = 16'h0000;
  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0] pc_next;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order entry FIFO for the fetch queue
//   clock/reset: clock, async active-high reset
//   push/din: enqueue an entry; pop: dequeue the head; clear: empty the FIFO (wins over push/pop)
//   head: current head entry; count: occupied entries; empty: count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  entry_t                   din,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != FULL || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and the IF/ID buffer
//   clock/reset: clock, async active-high reset
//   redirect/redirect_addr: taken branch/jump, flushes the queue and restarts fetch at redirect_addr
//   halt: stops new requests only
//   mem_req_*: sequential fetch requests; mem_rsp_*: in-order responses
//   out_*: queue head (instruction, address+2), popped on out_valid && out_ready; count: occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_addr,
  input  logic                   halt,
  output logic                   mem_req_valid,
  output logic [PC_W-1:0]        mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  logic [INSTR_W-1:0]     mem_rsp_data,
  output logic                   out_valid,
  output logic [INSTR_W-1:0]     out_instruction,
  output logic [PC_W-1:0]        out_pc_next,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (CW > OW ? CW : OW) + 1;
  logic [PC_W-1:0] fetch_pc, resp_pc;
  logic [OW-1:0] outstanding, discard_cnt;
  logic [SW-1:0] credit;
  logic req_fire, rsp_ok, push, pop, empty;
  entry_t din, head;
  // words still in flight that will be kept, plus words already queued
  assign credit = SW'(count) + SW'(outstanding) - SW'(discard_cnt);
  assign mem_req_valid = !reset && !halt && !redirect && outstanding < OW'(MAX_OUTSTANDING) && credit < SW'(DEPTH);
  assign mem_req_addr = fetch_pc;
  assign req_fire = mem_req_valid && mem_req_ready;
  // a response with nothing outstanding is ignored
  assign rsp_ok = mem_rsp_valid && outstanding != '0;
  assign push = rsp_ok && discard_cnt == '0 && !redirect;
  assign pop = out_valid && out_ready && !redirect;
  assign din = {mem_rsp_data, resp_pc + PC_INCR};
  assign out_valid = !empty;
  assign out_instruction = head.instruction;
  assign out_pc_next = head.pc_next;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .clear(redirect),
    .din(din),
    .head(head),
    .count(count),
    .empty(empty)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_VECTOR;
      resp_pc <= RESET_VECTOR;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_ok);
      fetch_pc <= redirect ? redirect_addr : req_fire ? fetch_pc + PC_INCR : fetch_pc;
      resp_pc <= redirect ? redirect_addr : push ? resp_pc + PC_INCR : resp_pc;
      discard_cnt <= redirect ? outstanding - OW'(rsp_ok) : discard_cnt - OW'(rsp_ok && discard_cnt != '0);
    end
  a_rsp_expected: assert property (@(posedge clock) disable iff (reset) mem_rsp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with a latency-programmable memory model
module tb_fetch_queue;
  logic clock = 0, reset = 1, redirect = 0, halt = 0, mem_req_ready = 1, mem_rsp_valid = 0, out_ready = 1;
  logic [15:0] redirect_addr = 0, mem_rsp_data = 0;
  logic mem_req_valid, out_valid;
  logic [15:0] mem_req_addr, out_instruction, out_pc_next;
  logic [2:0] count;
  int compared = 0, mismatched = 0, lat = 1, ecount = 0, n;
  typedef struct {logic [15:0] addr; int due;} req_t;
  req_t pend[$];
  always #5 clock = ~clock;
  fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_pc_next(out_pc_next), .out_ready(out_ready), .count(count)
  );
  // memory: word at addr is addr ^ C3C3, answered lat cycles after acceptance, in order
  always @(posedge clock or posedge reset)
    if (reset) begin
      pend.delete();
      ecount = 0;
    end else begin
      ecount++;
      if (mem_rsp_valid) void'(pend.pop_front());
      if (mem_req_valid && mem_req_ready) pend.push_back('{mem_req_addr, ecount + lat});
    end
  always @(negedge clock) begin
    mem_rsp_valid = !reset && pend.size() > 0 && pend[0].due <= ecount + 1;
    mem_rsp_data = pend.size() > 0 ? pend[0].addr ^ 16'hC3C3 : 16'h0000;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clock);
    #1;
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 30) begin
      tick();
      k++;
    end
    check(tag, out_valid, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_req", mem_req_valid, 0);
    check("rst_pcn", out_pc_next, 0);
    check("rst_instr", out_instruction, 0);
    reset = 0;
    #1;
    check("c1_req", {mem_req_valid, mem_req_addr}, 17'h10000);
    tick();
    check("c2_req", {mem_req_valid, mem_req_addr}, 17'h10002);
    check("c2_empty", out_valid, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("stream_valid", out_valid, 1);
      check("stream_pcn", out_pc_next, 16'(2 * k + 2));
      check("stream_instr", out_instruction, 16'(2 * k) ^ 16'hC3C3);
      check("stream_req", mem_req_addr, 16'(2 * k + 4));
      tick();
    end
    out_ready = 0;
    redirect = 1;
    redirect_addr = 16'h0100;
    #1;
    check("redir_noreq", mem_req_valid, 0);
    tick();
    redirect = 0;
    for (int k = 0; k < 10; k++) begin
      check("credit_bound", (int'(count) + int'(dut.outstanding)) <= 4, 1);
      tick();
    end
    check("full_count", count, 4);
    check("full_pcn", out_pc_next, 16'h0102);
    check("full_instr", out_instruction, 16'hC2C3);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pcn", out_pc_next, 16'(16'h0102 + 2 * k));
      check("drain_instr", out_instruction, 16'(16'h0100 + 2 * k) ^ 16'hC3C3);
      tick();
    end
    lat = 3;
    redirect = 1;
    redirect_addr = 16'h0200;
    tick();
    redirect = 0;
    tick();
    tick();
    check("t3_inflight", dut.outstanding, 2);
    redirect = 1;
    redirect_addr = 16'h0040;
    tick();
    redirect = 0;
    check("t3_discard", dut.discard_cnt, 2);
    check("t3_count", count, 0);
    check("t3_empty", out_valid, 0);
    wait_valid("t3_wait");
    check("t3_instr", out_instruction, 16'hC383);
    check("t3_pcn", out_pc_next, 16'h0042);
    lat = 2;
    out_ready = 0;
    redirect = 1;
    redirect_addr = 16'h0300;
    tick();
    redirect = 0;
    n = 0;
    while (!(dut.outstanding == 2 && mem_rsp_valid && out_valid) && n < 30) begin
      tick();
      n++;
    end
    check("t4_setup", n < 30, 1);
    out_ready = 1;
    redirect = 1;
    redirect_addr = 16'h0400;
    #1;
    check("t4_redir_noreq", mem_req_valid, 0);
    tick();
    redirect = 0;
    #1;
    check("t4_count", count, 0);
    check("t4_empty", out_valid, 0);
    check("t4_discard", dut.discard_cnt, 1);
    check("t4_req", {mem_req_valid, mem_req_addr}, 17'h10400);
    wait_valid("t4_wait");
    check("t4_instr", out_instruction, 16'hC7C3);
    check("t4_pcn", out_pc_next, 16'h0402);
    lat = 1;
    repeat (6) tick();
    redirect = 1;
    redirect_addr = 16'hFFFC;
    tick();
    redirect = 0;
    #1;
    check("wrap_req0", {mem_req_valid, mem_req_addr}, 17'h1FFFC);
    tick();
    check("wrap_req1", {mem_req_valid, mem_req_addr}, 17'h1FFFE);
    tick();
    check("wrap_req2", {mem_req_valid, mem_req_addr}, 17'h10000);
    wait_valid("wrap_wait");
    check("wrap_pcn0", out_pc_next, 16'hFFFE);
    check("wrap_instr0", out_instruction, 16'h3C3F);
    tick();
    check("wrap_pcn1", out_pc_next, 16'h0000);
    check("wrap_instr1", out_instruction, 16'h3C3D);
    tick();
    check("wrap_pcn2", out_pc_next, 16'h0002);
    check("wrap_instr2", out_instruction, 16'hC3C3);
    lat = 3;
    redirect = 1;
    redirect_addr = 16'h0500;
    tick();
    redirect = 0;
    tick();
    tick();
    check("halt_inflight", dut.outstanding, 2);
    halt = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("halt_noreq", mem_req_valid, 0);
      if (k == 2) begin
        check("halt_pcn0", {out_valid, out_pc_next}, 17'h10502);
        check("halt_instr0", out_instruction, 16'hC6C3);
      end
      if (k == 3) begin
        check("halt_pcn1", {out_valid, out_pc_next}, 17'h10504);
        check("halt_instr1", out_instruction, 16'hC6C1);
      end
      if (k == 5) check("halt_drained", count, 0);
      tick();
    end
    halt = 0;
    #1;
    check("halt_resume", {mem_req_valid, mem_req_addr}, 17'h10504);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
